// File: rtl/fifo_serial_tx.sv
// ----------------------------------------------------------------------------
// fifo_serial_tx
//
// Purpose:
//    Pulls bytes from the head of a show-ahead FIFO and shifts each one out on
//    an asynchronous-style serial line: one start bit (low), eight data bits
//    LSB first, an optional even-parity bit, and one stop bit (high). Every bit
//    lasts CLKS_PER_BIT clock cycles. Frames run back to back with exactly one
//    idle (high) cycle between them while the FIFO has data and enable is high.
//
// Optional feature:
//    FIFO_SERIAL_TX_PARITY_EN -- when defined, an even-parity bit (XOR of the
//    eight data bits) is inserted between the last data bit and the stop bit.
//    When undefined, the parity state and all of its logic are absent.
//
// Parameters:
//    CLKS_PER_BIT  clock cycles per serial bit, legal range 4..65535. The lower
//                  bound gives the FIFO flag time to settle after a read before
//                  the next start decision is taken.
//
// Ports:
//    clk         in   sole clock, all state changes on the rising edge
//    reset       in   synchronous, active-high reset
//    enable      in   permits starting a new frame (does not affect a frame
//                     already in progress)
//    fifo_empty  in   FIFO empty flag, only looked at while idle
//    fifo_data   in   byte at the head of the FIFO
//    fifo_read   out  one-cycle read strobe per byte consumed
//    tx          out  serial line, idles high
//    busy        out  high whenever a frame is in progress
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module fifo_serial_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_read,
   output logic       tx,
   output logic       busy
);

   // Reload value for the per-bit down-counter: a bit ends on the cycle the
   // counter reads zero, so loading N-1 yields exactly N cycles per bit.
   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

   // Frame sequencer states. The parity state only exists in parity builds.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] bit_timer;
   logic [15:0] bit_timer_next;
   logic [7:0]  shift_reg;
   logic [7:0]  shift_next;
   logic [2:0]  bit_index;
   logic [2:0]  bit_index_next;
   logic        tx_next;
   logic        fifo_read_next;
   logic        busy_next;
   logic        bit_done;

`ifdef FIFO_SERIAL_TX_PARITY_EN
   logic        parity_bit;
   logic        parity_next;
`endif

   // The current bit has been held for its full CLKS_PER_BIT cycles.
   assign bit_done = (bit_timer == 16'd0);

   // State and output registers. Reset wins over everything, including a
   // start condition present in the same cycle, and drops any frame in
   // flight without touching the FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bit_timer <= '0;
         shift_reg <= '0;
         bit_index <= '0;
         tx        <= 1'b1;
         fifo_read <= 1'b0;
         busy      <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         bit_timer <= bit_timer_next;
         shift_reg <= shift_next;
         bit_index <= bit_index_next;
         tx        <= tx_next;
         fifo_read <= fifo_read_next;
         busy      <= busy_next;
`ifdef FIFO_SERIAL_TX_PARITY_EN
         parity_bit <= parity_next;
`endif
      end
   end

   // Next-state and next-output logic. Outputs are computed here one cycle
   // ahead and registered above, so tx changes on the same edge that moves
   // the state machine into the state that owns that bit value.
   always_comb begin
      state_next     = state;
      bit_timer_next = bit_timer;
      shift_next     = shift_reg;
      bit_index_next = bit_index;
      tx_next        = tx;
      fifo_read_next = 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_next    = parity_bit;
`endif

      case (state)
         // Waiting for work. The byte is taken straight from the FIFO head on
         // the starting edge; the read strobe then pops it, so later changes
         // of fifo_data cannot disturb the frame.
         IDLE: begin
            tx_next = 1'b1;
            if (enable && !fifo_empty) begin
               shift_next     = fifo_data;
               fifo_read_next = 1'b1;
               tx_next        = 1'b0;
               bit_timer_next = BIT_LAST;
               state_next     = START;
`ifdef FIFO_SERIAL_TX_PARITY_EN
               parity_next    = ^fifo_data;
`endif
            end
         end

         // Start bit: line held low, then the LSB goes out.
         START: begin
            if (bit_done) begin
               tx_next        = shift_reg[0];
               bit_index_next = 3'd0;
               bit_timer_next = BIT_LAST;
               state_next     = DATA;
            end else begin
               bit_timer_next = bit_timer - 16'd1;
            end
         end

         // Data bits, LSB first. shift_reg[0] is the bit currently on the
         // line, so the following bit is shift_reg[1] before the shift.
         DATA: begin
            if (bit_done) begin
               bit_timer_next = BIT_LAST;
               if (bit_index == 3'd7) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                  tx_next    = parity_bit;
                  state_next = PARITY;
`else
                  tx_next    = 1'b1;
                  state_next = STOP;
`endif
               end else begin
                  tx_next        = shift_reg[1];
                  shift_next     = {1'b0, shift_reg[7:1]};
                  bit_index_next = bit_index + 3'd1;
               end
            end else begin
               bit_timer_next = bit_timer - 16'd1;
            end
         end

`ifdef FIFO_SERIAL_TX_PARITY_EN
         // Even-parity bit, captured together with the byte.
         PARITY: begin
            if (bit_done) begin
               tx_next        = 1'b1;
               bit_timer_next = BIT_LAST;
               state_next     = STOP;
            end else begin
               bit_timer_next = bit_timer - 16'd1;
            end
         end
`endif

         // Stop bit: line high. Returning to IDLE leaves tx high, which gives
         // the single idle cycle before the next start decision.
         STOP: begin
            if (bit_done) begin
               tx_next    = 1'b1;
               state_next = IDLE;
            end else begin
               bit_timer_next = bit_timer - 16'd1;
            end
         end

         default: begin
            tx_next    = 1'b1;
            state_next = IDLE;
         end
      endcase

      // busy mirrors the registered state, so it rises on the starting edge
      // and falls on the edge that re-enters IDLE.
      busy_next = (state_next != IDLE);
   end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// ----------------------------------------------------------------------------
// tb_fifo_serial_tx
//
// Self-checking bench for fifo_serial_tx with CLKS_PER_BIT = 4. A queue models
// the FIFO feeding the transmitter; every byte pushed into it is also pushed
// into an expected-frame queue. Each time the transmitter strobes fifo_read,
// the expected byte is popped and the whole frame is checked cycle by cycle on
// tx, busy and fifo_read. Outside frames the line must be idle. Build with
// +define+FIFO_SERIAL_TX_PARITY_EN to exercise the parity variant.
// ----------------------------------------------------------------------------
module tb_fifo_serial_tx;

   localparam int CLKS_PER_BIT = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_read;
   logic       tx;
   logic       busy;

   int testCount = 0;
   int failCount = 0;
   int cycleCount = 0;

   logic [7:0] fifoQ[$];
   logic [7:0] expQ[$];

   logic       frameActive = 1'b0;
   int         framePos = 0;
   logic [7:0] frameByte = 8'h00;
   int         frameDoneCount = 0;
   int         readCount = 0;
   int         lastReadCycle = 0;
   int         prevReadCycle = 0;
   int         readsBefore = 0;

   fifo_serial_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_read  (fifo_read),
      .tx         (tx),
      .busy       (busy)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Safety net in case a wait loop is ever left unbounded.
   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
      $fatal(1, "[TB] global timeout");
   end

   // Compare one observed value with its expected value and count it.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleCount);
      end
   endtask

   // Expected line level for bit k of a frame carrying byte b.
   function automatic logic expBit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (FRAME_BITS == 11 && k == 9) return ^b;
      return 1'b1;
   endfunction

   // Drive the FIFO head and flag from the model queue.
   task automatic refreshFifo();
      fifo_empty = (fifoQ.size() == 0);
      fifo_data  = (fifoQ.size() == 0) ? 8'h00 : fifoQ[0];
   endtask

   // Queue one byte into the FIFO and the matching expected frame.
   task automatic applyStimulus(input logic [7:0] b);
      fifoQ.push_back(b);
      expQ.push_back(b);
      refreshFifo();
   endtask

   // Advance one cycle and check outputs on the falling edge.
   task automatic tick();
      @(negedge clk);
      cycleCount++;
      if (reset) begin
         frameActive = 1'b0;
      end else if (fifo_read && !frameActive) begin
         readCount++;
         prevReadCycle = lastReadCycle;
         lastReadCycle = cycleCount;
         if (fifoQ.size() > 0) void'(fifoQ.pop_front());
         refreshFifo();
         checkOutput("scoreboard_has_entry", 32'(expQ.size() != 0), 32'd1);
         frameByte   = (expQ.size() != 0) ? expQ.pop_front() : 8'h00;
         frameActive = 1'b1;
         framePos    = 0;
      end
      if (frameActive) begin
         checkOutput("frame_tx", 32'(tx), 32'(expBit(frameByte, framePos / CLKS_PER_BIT)));
         checkOutput("frame_busy", 32'(busy), 32'd1);
         checkOutput("frame_read", 32'(fifo_read), 32'(framePos == 0));
         framePos++;
         if (framePos == FRAME_CYCLES) begin
            frameActive = 1'b0;
            frameDoneCount++;
         end
      end else begin
         checkOutput("idle_tx", 32'(tx), 32'd1);
         checkOutput("idle_busy", 32'(busy), 32'd0);
         checkOutput("idle_read", 32'(fifo_read), 32'd0);
      end
   endtask

   // Run until n more frames have completed, within a cycle budget.
   task automatic waitFrames(input int n, input int budget);
      int target;
      int spent;
      target = frameDoneCount + n;
      spent  = 0;
      while (frameDoneCount < target && spent < budget) begin
         tick();
         spent++;
      end
      checkOutput("frames_done_in_time", 32'(frameDoneCount >= target), 32'd1);
   endtask

   // Run until a frame has started, within a cycle budget.
   task automatic waitRead(input int budget);
      int spent;
      spent = 0;
      while (!frameActive && spent < budget) begin
         tick();
         spent++;
      end
      checkOutput("read_in_time", 32'(frameActive), 32'd1);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      refreshFifo();

      // Reset state.
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Empty FIFO with enable high: line stays idle, no reads.
      enable      = 1'b1;
      readsBefore = readCount;
      repeat (100) tick();
      checkOutput("empty_no_read", 32'(readCount - readsBefore), 32'd0);

      // Single frame 0x55.
      applyStimulus(8'h55);
      waitFrames(1, 200);
      tick();

      // Back-to-back frames 0xA3, 0x0F: reads one frame plus one idle apart.
      applyStimulus(8'hA3);
      applyStimulus(8'h0F);
      waitFrames(2, 300);
      checkOutput("b2b_read_spacing", 32'(lastReadCycle - prevReadCycle), 32'(FRAME_CYCLES + 1));
      tick();

      // Parity-relevant bytes (odd and even number of ones).
      applyStimulus(8'h07);
      applyStimulus(8'h03);
      waitFrames(2, 300);
      checkOutput("parity_read_spacing", 32'(lastReadCycle - prevReadCycle), 32'(FRAME_CYCLES + 1));
      tick();

      // Enable dropped during START of 0x12: frame completes, next byte waits.
      applyStimulus(8'h12);
      applyStimulus(8'h34);
      waitRead(50);
      enable = 1'b0;
      waitFrames(1, 200);
      readsBefore = readCount;
      repeat (20) tick();
      checkOutput("blocked_no_read", 32'(readCount - readsBefore), 32'd0);
      checkOutput("blocked_fifo_depth", 32'(fifoQ.size()), 32'd1);
      enable = 1'b1;
      waitFrames(1, 200);
      tick();

      // Reset during data bit 3 of 0xFF: frame aborted, next byte starts fresh.
      applyStimulus(8'hFF);
      applyStimulus(8'h3C);
      waitRead(50);
      repeat (16) tick();
      reset = 1'b1;
      tick();
      checkOutput("abort_tx", 32'(tx), 32'd1);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      repeat (2) tick();
      checkOutput("reset_priority_depth", 32'(fifoQ.size()), 32'd1);
      reset = 1'b0;
      waitFrames(1, 200);
      repeat (3) tick();
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
      checkOutput("fifo_drained", 32'(fifoQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on posedge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: permits starting a new frame.
REQ-005 SHALL have port fifo_empty, input, 1: FIFO is_empty flag.
REQ-006 SHALL have port fifo_data, input, 8: FIFO data_out, the byte at the head of the FIFO.
REQ-007 SHALL have port fifo_read, output, 1: FIFO read_en; one-cycle pulse per byte consumed.
REQ-008 SHALL have port tx, output, 1: serial line, idle high.
REQ-009 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (macro-dependent), STOP; all outputs registered.
REQ-011 In IDLE with enable=1 and fifo_empty=0 at edge E0: shift register <= fifo_data, fifo_read <= 1, tx <= 0, state <= START.
REQ-012 fifo_read SHALL be high for exactly the one cycle following E0 and low at all other times.
REQ-013 The captured byte SHALL come from fifo_data sampled at E0; fifo_data after E0 is ignored for that frame.
REQ-014 Each of START, every DATA bit, PARITY and STOP SHALL hold tx for exactly CLKS_PER_BIT cycles, timed by a 16-bit down-counter.
REQ-015 START: tx=0. DATA: 8 bits, LSB first. STOP: tx=1.
REQ-016 At the end of STOP, state SHALL return to IDLE; the next start condition is evaluated on the following edge.
REQ-017 Back-to-back frames: minimum period of 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity); exactly one idle cycle with tx=1 between frames.
REQ-018 Deasserting enable mid-frame SHALL NOT affect the frame in progress; it only blocks the next start.
REQ-019 fifo_empty SHALL be sampled only in IDLE; staleness of the FIFO flag for up to 2 cycles after a read is tolerated, because CLKS_PER_BIT>=4 guarantees it has settled.
REQ-020 With fifo_empty=1 or enable=0 in IDLE: state stays IDLE, tx=1, fifo_read=0.
REQ-021 busy SHALL go high at E0 and low at the edge that enters IDLE.

Reset
REQ-022 On reset=1 at any edge: state=IDLE, tx=1, fifo_read=0, busy=0, counters=0, shift register=0.
REQ-023 Reset mid-frame SHALL abort the frame (byte lost, FIFO not rewound) and issue no fifo_read.
REQ-024 Reset SHALL take priority over every start condition in the same cycle.

Configuration
REQ-025 Macro FIFO_SERIAL_TX_PARITY_EN defined: a PARITY state SHALL follow DATA and drive the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-026 Macro FIFO_SERIAL_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent; DATA goes directly to STOP.

Verification (CLKS_PER_BIT=4)
REQ-027 FIFO holds 0x55, enable=1 -> one fifo_read pulse; tx=0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; busy high for 40 cycles.
REQ-028 fifo_empty=1, enable=1 for 100 cycles -> tx=1, fifo_read=0 and busy=0 throughout.
REQ-029 FIFO holds 0xA3 then 0x0F -> two fifo_read pulses 41 cycles apart; exactly one idle cycle with tx=1 between the frames.
REQ-030 reset pulsed during DATA bit 3 of 0xFF -> tx=1 and busy=0 on the next cycle; the next queued byte starts a fresh frame after reset releases.
REQ-031 Macro defined, byte 0x07 -> parity bit 1 between DATA and STOP; byte 0x03 -> parity bit 0; frame length 44 cycles.
REQ-032 enable dropped during START of 0x12 -> frame completes unchanged; no further fifo_read until enable returns high.
